echo_queue: RTL and testbench
=============================

Name: echo_queue

Overview:
- Parametrised successor to the single-entry echo server.
- Accepts `say` (one value) and `say2` (a,b pair) requests into a DEPTH-entry tagged FIFO.
- Replays them in order on the `heard`/`heard2` indication channels. Adds configurable widths, queue depth, an LED register, and echo/drop statistics.
- Sits between the host request portal and the indication portal; replaces the one-deep busy/delay pair.

Parameters:
- V_WIDTH, 32, width of say/heard value.
- AB_WIDTH, 16, width of each say2/heard2 field a and b.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- LED_WIDTH, 8, width of LED register.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  asynchronous active-high reset.
- say__ENA  input  1  say request valid.
- say_v  input  V_WIDTH  say payload.
- say__RDY  output  1  say can be accepted.
- say2__ENA  input  1  say2 request valid.
- say2_a  input  AB_WIDTH  say2 field a.
- say2_b  input  AB_WIDTH  say2 field b.
- say2__RDY  output  1  say2 can be accepted.
- setLeds__ENA  input  1  LED write.
- setLeds_v  input  LED_WIDTH  LED value.
- setLeds__RDY  output  1  constant 1.
- heard__ENA  output  1  head entry is a say and is being delivered.
- heard_v  output  V_WIDTH  head value.
- heard__RDY  input  1  indication sink ready for heard.
- heard2__ENA  output  1  head entry is a say2 and is being delivered.
- heard2_a  output  AB_WIDTH  head field a.
- heard2_b  output  AB_WIDTH  head field b.
- heard2__RDY  input  1  sink ready for heard2.
- leds  output  LED_WIDTH  LED register.
- occupancy  output  log2(DEPTH)+1  entries currently queued.
- echo_count  output  32  messages delivered.
- drop_count  output  16  say2 requests lost to collision.

Behaviour:
- Reset: asynchronous on RST high; cleared immediately, independent of CLK.
  - Clears read/write pointers, occupancy, leds, echo_count and drop_count to 0. Storage contents are don't-care.
  - While RST is high, heard__ENA=0, heard2__ENA=0, say__RDY=say2__RDY=1 (queue empty).
- Entry format: 1-bit type (0=say, 1=say2) plus payload of max(V_WIDTH, 2*AB_WIDTH) bits.
  - say: v is zero-extended into the payload.
  - say2: payload is {a,b}, with b in the low bits.
- Ready signals: say__RDY = say2__RDY = (occupancy != DEPTH). Both are combinational from registered state only, never from any ENA.
- Enqueue: on a cycle with say__ENA && say__RDY, write {0,v}; else on say2__ENA && say2__RDY, write {1,a,b}.
- Collision: if say__ENA and say2__ENA are both high with RDY=1, say wins. say2 is discarded and drop_count increments, saturating at 16'hFFFF.
- Full queue: ENA while RDY=0 is ignored and not counted; the caller must hold the request.
- Dequeue: the head is valid when occupancy != 0.
  - heard__ENA = valid && type==0 && heard__RDY.
  - heard2__ENA = valid && type==1 && heard2__RDY.
  - On either ENA, the read pointer advances and echo_count increments, wrapping modulo 2^32.
  - The head stays stalled while the selected channel's RDY is low. No reordering: a say2 head blocks later says.
- Payload outputs always show the head entry (heard_v = low V_WIDTH bits), even when ENA=0.
- Latency: no bypass. A request accepted at edge k is earliest visible on ENA in the cycle after edge k (1 cycle). Throughput is 1 message/cycle.
- Simultaneous enqueue and dequeue: occupancy is unchanged and both pointers advance. This is allowed at any occupancy below DEPTH; when full, no enqueue is possible that cycle.
- Pointers are log2(DEPTH) bits and wrap naturally at DEPTH.
- setLeds__ENA loads leds on the next edge. It is independent of the queue and may coincide with any other event.
- Reset asserted mid-transfer: queued entries are lost and counters are cleared; no ENA pulse is generated after reset.

Test Plan:
- Reset, then say v=0x12345678 with heard__RDY=1 → next cycle heard__ENA=1, heard_v=0x12345678; echo_count=1; occupancy back to 0.
- heard__RDY=heard2__RDY=0; enqueue say 1, say2 (a=0xAAAA, b=0x5555), say 3, say 4 → occupancy=4, say__RDY=0. A 5th say is ignored. Release both RDYs → heard 1, heard2 AAAA/5555, heard 3, heard 4 in consecutive cycles; echo_count=4.
- say__ENA and say2__ENA together (v=7, a=1, b=2) → only heard v=7 delivered; drop_count=1.
- Head is say2 with heard2__RDY=0 and heard__RDY=1 → no ENA for 10 cycles and occupancy held. Raise heard2__RDY → delivery.
- Continuous say every cycle with RDY=1 for 20 cycles → 20 heard pulses in order, occupancy never exceeds 1, pointers wrap cleanly.
- setLeds v=0xA5 mid-traffic, then assert RST asynchronously mid-cycle with 3 entries queued → leds=0, occupancy=0, heard__ENA=0 immediately, before the next edge.

Source files
------------

// File: rtl/echo_queue.sv
// echo_queue: DEPTH-entry tagged FIFO that replays say/say2 requests in order
// on the heard/heard2 indication channels, with an LED register and
// echo/drop statistics.
module echo_queue #(
  parameter int V_WIDTH   = 32,
  parameter int AB_WIDTH  = 16,
  parameter int DEPTH     = 4,
  parameter int LED_WIDTH = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     say__ENA,
  input  logic [V_WIDTH-1:0]       say_v,
  output logic                     say__RDY,
  input  logic                     say2__ENA,
  input  logic [AB_WIDTH-1:0]      say2_a,
  input  logic [AB_WIDTH-1:0]      say2_b,
  output logic                     say2__RDY,
  input  logic                     setLeds__ENA,
  input  logic [LED_WIDTH-1:0]     setLeds_v,
  output logic                     setLeds__RDY,
  output logic                     heard__ENA,
  output logic [V_WIDTH-1:0]       heard_v,
  input  logic                     heard__RDY,
  output logic                     heard2__ENA,
  output logic [AB_WIDTH-1:0]      heard2_a,
  output logic [AB_WIDTH-1:0]      heard2_b,
  input  logic                     heard2__RDY,
  output logic [LED_WIDTH-1:0]     leds,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [31:0]              echo_count,
  output logic [15:0]              drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam int PW = (V_WIDTH > 2*AB_WIDTH) ? V_WIDTH : 2*AB_WIDTH;
  localparam logic [OW-1:0] FULL = OW'(DEPTH);

  // t=0: say (v zero-extended), t=1: say2 ({a,b}, b in the low bits)
  typedef struct packed {
    logic          t;
    logic [PW-1:0] p;
  } entry_t;

  entry_t                 r_mem [DEPTH];
  logic [AW-1:0]          r_wptr, r_rptr;
  logic [OW-1:0]          r_occ;
  logic [LED_WIDTH-1:0]   r_leds;
  logic [31:0]            r_echo;
  logic [15:0]            r_drop;

  logic   w_full, w_valid;
  logic   w_enq_say, w_enq_say2, w_enq, w_deq, w_drop;
  entry_t w_new, w_head;

  assign w_full     = (r_occ == FULL);
  assign w_valid    = (r_occ != '0);
  assign w_enq_say  = say__ENA && !w_full;
  // say wins a collision; the losing say2 is counted as a drop
  assign w_enq_say2 = say2__ENA && !say__ENA && !w_full;
  assign w_drop     = say2__ENA && say__ENA && !w_full;
  assign w_enq      = w_enq_say || w_enq_say2;
  assign w_head     = r_mem[r_rptr];
  assign w_deq      = heard__ENA || heard2__ENA;

  assign say__RDY     = !w_full;
  assign say2__RDY    = !w_full;
  assign setLeds__RDY = 1'b1;
  assign heard__ENA   = w_valid && !w_head.t && heard__RDY;
  assign heard2__ENA  = w_valid &&  w_head.t && heard2__RDY;
  assign heard_v      = w_head.p[V_WIDTH-1:0];
  assign heard2_b     = w_head.p[AB_WIDTH-1:0];
  assign heard2_a     = w_head.p[2*AB_WIDTH-1:AB_WIDTH];
  assign leds         = r_leds;
  assign occupancy    = r_occ;
  assign echo_count   = r_echo;
  assign drop_count   = r_drop;

  // Build the entry to enqueue from whichever request is accepted
  always_comb begin
    w_new   = '0;
    w_new.t = w_enq_say2;
    if (w_enq_say2) w_new.p[2*AB_WIDTH-1:0] = {say2_a, say2_b};
    else            w_new.p[V_WIDTH-1:0]    = say_v;
  end

  // Storage array; contents need no reset since occupancy gates validity
  always_ff @(posedge CLK) begin
    if (w_enq) r_mem[r_wptr] <= w_new;
  end

  // Pointers, occupancy, LEDs and statistics
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
      r_leds <= '0;
      r_echo <= '0;
      r_drop <= '0;
    end else begin
      if (w_enq) r_wptr <= r_wptr + 1'b1;
      if (w_deq) begin
        r_rptr <= r_rptr + 1'b1;
        r_echo <= r_echo + 32'd1;
      end
      r_occ <= r_occ + OW'(w_enq) - OW'(w_deq);
      if (w_drop && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
      if (setLeds__ENA) r_leds <= setLeds_v;
    end
  end

endmodule

// File: tb/tb_echo_queue.sv
// Self-checking bench for echo_queue: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_echo_queue;
  localparam int DEPTH = 4;

  logic        CLK = 0, RST = 1;
  logic        say__ENA = 0, say2__ENA = 0, setLeds__ENA = 0;
  logic [31:0] say_v = 0;
  logic [15:0] say2_a = 0, say2_b = 0;
  logic [7:0]  setLeds_v = 0;
  logic        heard__RDY = 0, heard2__RDY = 0;
  logic        say__RDY, say2__RDY, setLeds__RDY, heard__ENA, heard2__ENA;
  logic [31:0] heard_v, echo_count;
  logic [15:0] heard2_a, heard2_b, drop_count;
  logic [7:0]  leds;
  logic [2:0]  occupancy;

  echo_queue #(.V_WIDTH(32), .AB_WIDTH(16), .DEPTH(DEPTH), .LED_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST),
    .say__ENA(say__ENA), .say_v(say_v), .say__RDY(say__RDY),
    .say2__ENA(say2__ENA), .say2_a(say2_a), .say2_b(say2_b), .say2__RDY(say2__RDY),
    .setLeds__ENA(setLeds__ENA), .setLeds_v(setLeds_v), .setLeds__RDY(setLeds__RDY),
    .heard__ENA(heard__ENA), .heard_v(heard_v), .heard__RDY(heard__RDY),
    .heard2__ENA(heard2__ENA), .heard2_a(heard2_a), .heard2_b(heard2_b),
    .heard2__RDY(heard2__RDY),
    .leds(leds), .occupancy(occupancy), .echo_count(echo_count), .drop_count(drop_count)
  );

  always #5 CLK = ~CLK;

  // Reference model: an ordered list of messages plus counters
  typedef struct packed { logic t; logic [31:0] p; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_echo = 0;
  logic [15:0] m_drop = 0;
  logic [7:0]  m_leds = 0;
  int n_checks = 0, n_errors = 0;

  // Advance one clock edge, updating the model from the inputs seen before it
  task automatic cycle();
    bit full, deq, es, es2, dr, le;
    ent_t e1, e2;
    logic [7:0] lv;
    full = (mq.size() == DEPTH);
    deq  = 0;
    if (mq.size() > 0) deq = mq[0].t ? heard2__RDY : heard__RDY;
    es  = say__ENA && !full;
    es2 = say2__ENA && !say__ENA && !full;
    dr  = say__ENA && say2__ENA && !full;
    e1  = {1'b0, say_v};
    e2  = {1'b1, say2_a, say2_b};
    le  = setLeds__ENA;
    lv  = setLeds_v;
    @(posedge CLK);
    if (deq) begin void'(mq.pop_front()); m_echo = m_echo + 1; end
    if (es)  mq.push_back(e1);
    if (es2) mq.push_back(e2);
    if (dr && m_drop != 16'hFFFF) m_drop = m_drop + 1;
    if (le) m_leds = lv;
    #1;
  endtask

  task automatic quiet();
    say__ENA = 0; say2__ENA = 0; setLeds__ENA = 0;
  endtask

  task automatic test_reset();
    heard__RDY = 1; heard2__RDY = 1;
    #3;
    n_checks++;
    if (heard__ENA !== 0 || heard2__ENA !== 0 || say__RDY !== 1 || say2__RDY !== 1 ||
        setLeds__RDY !== 1 || occupancy !== 0 || echo_count !== 0 || drop_count !== 0 || leds !== 0) begin
      n_errors++;
      $display("FAIL reset_state: ena=%b/%b rdy=%b/%b occ=%0d echo=%0d drop=%0d leds=%h, need 0/0 1/1 0 0 0 00",
               heard__ENA, heard2__ENA, say__RDY, say2__RDY, occupancy, echo_count, drop_count, leds);
    end
    @(negedge CLK); RST = 0;
    @(posedge CLK); #1;
  endtask

  task automatic test_single();
    heard__RDY = 1;
    say__ENA = 1; say_v = 32'h12345678;
    cycle(); quiet(); #1;
    n_checks++;
    if (heard__ENA !== 1 || heard_v !== 32'h12345678 || occupancy !== 1) begin
      n_errors++;
      $display("FAIL single_deliver: ena=%b v=%h occ=%0d, need 1 12345678 1", heard__ENA, heard_v, occupancy);
    end
    cycle();
    n_checks++;
    if (echo_count !== 1 || occupancy !== 0 || heard__ENA !== 0) begin
      n_errors++;
      $display("FAIL single_after: echo=%0d occ=%0d ena=%b, need 1 0 0", echo_count, occupancy, heard__ENA);
    end
  endtask

  task automatic test_fill();
    logic        et [4] = '{0, 1, 0, 0};
    logic [31:0] ev [4] = '{32'd1, 32'hAAAA5555, 32'd3, 32'd4};
    logic [31:0] e0;
    heard__RDY = 0; heard2__RDY = 0;
    e0 = m_echo;
    say__ENA = 1; say_v = 1; cycle(); quiet();
    say2__ENA = 1; say2_a = 16'hAAAA; say2_b = 16'h5555; cycle(); quiet();
    say__ENA = 1; say_v = 3; cycle();
    say_v = 4; cycle();
    #1;
    n_checks++;
    if (occupancy !== 4 || say__RDY !== 0 || say2__RDY !== 0) begin
      n_errors++;
      $display("FAIL fill_full: occ=%0d rdy=%b/%b, need 4 0/0", occupancy, say__RDY, say2__RDY);
    end
    say_v = 5; cycle(); quiet(); #1;
    n_checks++;
    if (occupancy !== 4 || mq.size() != 4) begin
      n_errors++;
      $display("FAIL fill_ignore5: occ=%0d, need 4", occupancy);
    end
    heard__RDY = 1; heard2__RDY = 1; #1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (heard__ENA !== !et[i] || heard2__ENA !== et[i] ||
          (et[i] == 0 && heard_v !== ev[i]) ||
          (et[i] == 1 && {heard2_a, heard2_b} !== ev[i])) begin
        n_errors++;
        $display("FAIL fill_drain%0d: ena=%b/%b v=%h ab=%h%h, need %b/%b %h",
                 i, heard__ENA, heard2__ENA, heard_v, heard2_a, heard2_b, !et[i], et[i], ev[i]);
      end
      cycle();
    end
    n_checks++;
    if (echo_count !== e0 + 4 || occupancy !== 0) begin
      n_errors++;
      $display("FAIL fill_count: echo=%0d occ=%0d, need %0d 0", echo_count, occupancy, e0 + 4);
    end
  endtask

  task automatic test_collision();
    logic [15:0] d0;
    d0 = m_drop;
    heard__RDY = 1; heard2__RDY = 1;
    say__ENA = 1; say_v = 7; say2__ENA = 1; say2_a = 1; say2_b = 2;
    cycle(); quiet(); #1;
    n_checks++;
    if (heard__ENA !== 1 || heard_v !== 7 || heard2__ENA !== 0 || occupancy !== 1 || drop_count !== d0 + 1) begin
      n_errors++;
      $display("FAIL collision: ena=%b/%b v=%0d occ=%0d drop=%0d, need 1/0 7 1 %0d",
               heard__ENA, heard2__ENA, heard_v, occupancy, drop_count, d0 + 1);
    end
    cycle();
    n_checks++;
    if (occupancy !== 0 || heard2__ENA !== 0) begin
      n_errors++;
      $display("FAIL collision_after: occ=%0d ena2=%b, need 0 0", occupancy, heard2__ENA);
    end
  endtask

  task automatic test_stall();
    heard__RDY = 1; heard2__RDY = 0;
    say2__ENA = 1; say2_a = 16'h1234; say2_b = 16'h5678; cycle(); quiet();
    say__ENA = 1; say_v = 32'h99; cycle(); quiet();
    for (int i = 0; i < 10; i++) begin
      #1;
      n_checks++;
      if (heard__ENA !== 0 || heard2__ENA !== 0 || occupancy !== 2) begin
        n_errors++;
        $display("FAIL stall%0d: ena=%b/%b occ=%0d, need 0/0 2", i, heard__ENA, heard2__ENA, occupancy);
      end
      cycle();
    end
    heard2__RDY = 1; #1;
    n_checks++;
    if (heard2__ENA !== 1 || heard2_a !== 16'h1234 || heard2_b !== 16'h5678 || heard__ENA !== 0) begin
      n_errors++;
      $display("FAIL stall_release: ena2=%b a=%h b=%h ena=%b, need 1 1234 5678 0",
               heard2__ENA, heard2_a, heard2_b, heard__ENA);
    end
    cycle(); #1;
    n_checks++;
    if (heard__ENA !== 1 || heard_v !== 32'h99 || occupancy !== 1) begin
      n_errors++;
      $display("FAIL stall_next: ena=%b v=%h occ=%0d, need 1 99 1", heard__ENA, heard_v, occupancy);
    end
    cycle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] prev;
    heard__RDY = 1; heard2__RDY = 1;
    for (int i = 0; i < 20; i++) begin
      say__ENA = 1; say_v = $urandom; #1;
      if (i > 0) begin
        n_checks++;
        if (heard__ENA !== 1 || heard_v !== prev || occupancy > 1) begin
          n_errors++;
          $display("FAIL b2b%0d: ena=%b v=%h occ=%0d, need 1 %h <=1", i, heard__ENA, heard_v, occupancy, prev);
        end
      end
      prev = say_v;
      cycle();
    end
    quiet(); #1;
    n_checks++;
    if (heard__ENA !== 1 || heard_v !== prev || occupancy !== 1) begin
      n_errors++;
      $display("FAIL b2b_last: ena=%b v=%h occ=%0d, need 1 %h 1", heard__ENA, heard_v, occupancy, prev);
    end
    cycle();
  endtask

  task automatic test_random();
    bit exp_e, exp_e2;
    for (int i = 0; i < 400; i++) begin
      say__ENA     = ($urandom_range(0, 99) < 45);
      say2__ENA    = ($urandom_range(0, 99) < 35);
      setLeds__ENA = ($urandom_range(0, 99) < 10);
      say_v = $urandom; say2_a = 16'($urandom); say2_b = 16'($urandom);
      setLeds_v = 8'($urandom);
      heard__RDY  = ($urandom_range(0, 99) < 60);
      heard2__RDY = ($urandom_range(0, 99) < 60);
      #1;
      exp_e  = mq.size() > 0 && !mq[0].t && heard__RDY;
      exp_e2 = mq.size() > 0 &&  mq[0].t && heard2__RDY;
      n_checks++;
      if (heard__ENA !== exp_e || heard2__ENA !== exp_e2 || occupancy !== 3'(mq.size()) ||
          say__RDY !== (mq.size() != DEPTH) || say2__RDY !== (mq.size() != DEPTH) ||
          echo_count !== m_echo || drop_count !== m_drop || leds !== m_leds ||
          (mq.size() > 0 && (heard_v !== mq[0].p || {heard2_a, heard2_b} !== mq[0].p))) begin
        n_errors++;
        $display("FAIL random%0d: ena=%b/%b occ=%0d echo=%0d drop=%0d leds=%h v=%h, need %b/%b %0d %0d %0d %h %h",
                 i, heard__ENA, heard2__ENA, occupancy, echo_count, drop_count, leds, heard_v,
                 exp_e, exp_e2, mq.size(), m_echo, m_drop, m_leds, mq.size() > 0 ? mq[0].p : 32'h0);
      end
      cycle();
    end
    quiet();
  endtask

  task automatic test_async_reset();
    heard__RDY = 0; heard2__RDY = 0;
    while (mq.size() > 0) begin heard__RDY = 1; heard2__RDY = 1; cycle(); end
    heard__RDY = 0; heard2__RDY = 0;
    setLeds__ENA = 1; setLeds_v = 8'hA5;
    say__ENA = 1; say_v = 32'h11; cycle(); setLeds__ENA = 0;
    say_v = 32'h22; cycle();
    say_v = 32'h33; cycle(); quiet(); #1;
    n_checks++;
    if (leds !== 8'hA5 || occupancy !== 3) begin
      n_errors++;
      $display("FAIL pre_reset: leds=%h occ=%0d, need a5 3", leds, occupancy);
    end
    heard__RDY = 1; #1;
    n_checks++;
    if (heard__ENA !== 1) begin
      n_errors++;
      $display("FAIL pre_reset_ena: ena=%b, need 1", heard__ENA);
    end
    RST = 1; #1;
    mq.delete(); m_echo = 0; m_drop = 0; m_leds = 0;
    n_checks++;
    if (heard__ENA !== 0 || occupancy !== 0 || leds !== 0 || echo_count !== 0 ||
        drop_count !== 0 || say__RDY !== 1) begin
      n_errors++;
      $display("FAIL async_reset: ena=%b occ=%0d leds=%h echo=%0d drop=%0d rdy=%b, need 0 0 00 0 0 1",
               heard__ENA, occupancy, leds, echo_count, drop_count, say__RDY);
    end
    @(negedge CLK); RST = 0;
    @(posedge CLK); #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (heard__ENA !== 0 || occupancy !== 0) begin
        n_errors++;
        $display("FAIL post_reset%0d: ena=%b occ=%0d, need 0 0", i, heard__ENA, occupancy);
      end
      cycle();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_collision();
    test_stall();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, need completion");
    $fatal(1);
  end
endmodule
